// File: rtl/refresh_scheduler.sv
// Per-scanline DRAM refresh request generator with H/V timing counters and a
// refresh-window protocol monitor. Optional short NTSC line: REFRESH_SHORT_LINE_EN.
module refresh_scheduler #(
    parameter int unsigned REFRESH_POS = 538,
    parameter int unsigned START_LEN   = 8,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned MAX_REFRESH = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mclk_en,
    input  logic        pal,
    input  logic        interlace,
    input  logic        refresh_enable,
    input  logic        refresh,
    input  logic        err_clr,
    output logic        start,
    output logic [10:0] hpos,
    output logic [8:0]  vpos,
    output logic        field,
    output logic        line_start,
    output logic        refresh_err
);
    localparam logic [10:0] LineLen    = 11'd1364;
`ifdef REFRESH_SHORT_LINE_EN
    localparam logic [10:0] ShortLen   = 11'd1360;
`endif
    localparam logic [8:0]  LastNtsc   = 9'd261;
    localparam logic [8:0]  LastPal    = 9'd311;
    localparam logic [10:0] StartLo    = 11'(REFRESH_POS);
    localparam logic [10:0] StartHi    = 11'(REFRESH_POS + START_LEN);
    localparam logic [6:0]  AckTimeout = 7'(ACK_TIMEOUT);
    localparam logic [6:0]  MaxRefresh = 7'(MAX_REFRESH);

    typedef enum logic [1:0] {StIdle, StWait, StActive} mon_state_e;

    logic [10:0] hpos_q, hpos_d;
    logic [8:0]  vpos_q, vpos_d;
    logic        field_q, field_d;
    logic        pal_q, pal_d;
    logic        ilace_q, ilace_d;
    logic        start_q, start_d;
    logic        line_start_q, line_start_d;
    logic        err_q, err_d;
    mon_state_e  state_q, state_d;
    logic [6:0]  mctr_q, mctr_d;

    logic [10:0] line_len;
    logic [8:0]  last_line;
    logic        line_end;
    logic [6:0]  mctr_inc;
    logic        err_set;

    always_comb begin : timing
        line_len = LineLen;
`ifdef REFRESH_SHORT_LINE_EN
        if (!pal_q && !ilace_q && field_q && (vpos_q == 9'd240)) begin
            line_len = ShortLen;
        end
`endif
        last_line = pal_q ? LastPal : LastNtsc;
        if (ilace_q && field_q) begin
            last_line = last_line + 9'd1;
        end
        line_end = mclk_en && (hpos_q == line_len - 11'd1);

        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        field_d = field_q;
        pal_d   = pal_q;
        ilace_d = ilace_q;
        if (mclk_en) begin
            if (line_end) begin
                hpos_d = '0;
                if (vpos_q == last_line) begin
                    // Video mode only changes on a frame boundary
                    vpos_d  = '0;
                    field_d = ~field_q;
                    pal_d   = pal;
                    ilace_d = interlace;
                end else begin
                    vpos_d = vpos_q + 9'd1;
                end
            end else begin
                hpos_d = hpos_q + 11'd1;
            end
        end
        line_start_d = line_end;
        start_d      = refresh_enable && (hpos_q >= StartLo) && (hpos_q < StartHi);
    end

    always_comb begin : monitor
        state_d  = state_q;
        mctr_d   = mctr_q;
        err_set  = 1'b0;
        mctr_inc = (mctr_q == 7'h7f) ? mctr_q : mctr_q + 7'd1;
        unique case (state_q)
            StIdle: begin
                if (start_d && !start_q) begin
                    state_d = StWait;
                    mctr_d  = '0;
                end else if (refresh) begin
                    err_set = 1'b1;
                end
            end
            StWait: begin
                if (refresh) begin
                    state_d = StActive;
                    mctr_d  = 7'd1;
                end else begin
                    mctr_d = mctr_inc;
                    if (mctr_inc >= AckTimeout) begin
                        err_set = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StActive: begin
                if (!refresh) begin
                    state_d = StIdle;
                end else begin
                    mctr_d = mctr_inc;
                    if (mctr_inc > MaxRefresh) begin
                        err_set = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A new error outranks a clear in the same cycle
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q       <= '0;
            vpos_q       <= '0;
            field_q      <= 1'b0;
            pal_q        <= 1'b0;
            ilace_q      <= 1'b0;
            start_q      <= 1'b0;
            line_start_q <= 1'b0;
            err_q        <= 1'b0;
            state_q      <= StIdle;
            mctr_q       <= '0;
        end else begin
            hpos_q       <= hpos_d;
            vpos_q       <= vpos_d;
            field_q      <= field_d;
            pal_q        <= pal_d;
            ilace_q      <= ilace_d;
            start_q      <= start_d;
            line_start_q <= line_start_d;
            err_q        <= err_d;
            state_q      <= state_d;
            mctr_q       <= mctr_d;
        end
    end

    assign start       = start_q;
    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign field       = field_q;
    assign line_start  = line_start_q;
    assign refresh_err = err_q;

endmodule
